// File: rtl/ir_fetch_ctrl.sv
// Instruction fetch sequencer: keeps the fetch PC, issues one outstanding
// instruction-memory read at a time and loads each returned word into the IR.
module ir_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          TIMEOUT  = 64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        io_en,
   input  logic        io_redirect_valid,
   input  logic [31:0] io_redirect_pc,
   output logic        io_mem_req_valid,
   input  logic        io_mem_req_ready,
   output logic [31:0] io_mem_req_addr,
   input  logic        io_mem_resp_valid,
   input  logic [31:0] io_mem_resp_data,
   input  logic        io_mem_resp_err,
   output logic        io_ir_we,
   output logic [31:0] io_ir_wdata,
   output logic        io_ir_valid,
   output logic [31:0] io_ir_pc,
   input  logic        io_dec_ready,
   output logic        io_fault
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, FULL, FAULT} state_t;

   state_t          state, state_n;
   logic [31:0]     pc, pc_n;
   logic [31:0]     req_addr, req_addr_n;
   logic [31:0]     ir_pc, ir_pc_n;
   logic            discard, discard_n;
   logic [TW-1:0]   tcnt, tcnt_n;
   logic [31:0]     redirect_pc;
   logic            timeout_hit;

   assign redirect_pc = io_redirect_pc & 32'hFFFF_FFFC;
   assign timeout_hit = (tcnt == TW'(TIMEOUT - 1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         req_addr <= RESET_PC;
         ir_pc    <= RESET_PC;
         discard  <= 1'b0;
         tcnt     <= '0;
      end else begin
         state    <= state_n;
         pc       <= pc_n;
         req_addr <= req_addr_n;
         ir_pc    <= ir_pc_n;
         discard  <= discard_n;
         tcnt     <= tcnt_n;
      end
   end

   // Normal sequencing first; a redirect then overrides it. The request
   // address is only reloaded on entry to REQ so it never moves mid-handshake.
   always_comb begin
      state_n    = state;
      pc_n       = pc;
      req_addr_n = req_addr;
      ir_pc_n    = ir_pc;
      discard_n  = discard;
      tcnt_n     = tcnt;
      io_ir_we   = 1'b0;

      case (state)
         IDLE: begin
            if (io_en) state_n = REQ;
         end
         REQ: begin
            if (io_mem_req_ready) begin
               state_n = WAIT;
               tcnt_n  = '0;
            end
         end
         WAIT: begin
            if (io_mem_resp_valid) begin
               if (discard) begin
                  discard_n = 1'b0;
                  state_n   = REQ;
               end else if (io_mem_resp_err) begin
                  state_n = FAULT;
               end else begin
                  io_ir_we = 1'b1;
                  ir_pc_n  = pc;
                  state_n  = FULL;
               end
            end else if (timeout_hit) begin
               discard_n = 1'b0;
               state_n   = FAULT;
            end else begin
               tcnt_n = tcnt + TW'(1);
            end
         end
         FULL: begin
            if (io_dec_ready) begin
               pc_n    = pc + 32'd4;
               state_n = io_en ? REQ : IDLE;
            end
         end
         default: ;
      endcase

      // An outstanding request must still see its response before the new
      // PC is fetched; a response or timeout arriving now closes it out.
      if (io_redirect_valid) begin
         pc_n     = redirect_pc;
         ir_pc_n  = ir_pc;
         io_ir_we = 1'b0;
         case (state)
            REQ: discard_n = 1'b1;
            WAIT: begin
               if (io_mem_resp_valid || timeout_hit) begin
                  discard_n = 1'b0;
                  state_n   = io_en ? REQ : IDLE;
               end else begin
                  discard_n = 1'b1;
                  state_n   = WAIT;
               end
            end
            default: state_n = io_en ? REQ : IDLE;
         endcase
      end

      if (state_n == REQ && state != REQ) req_addr_n = pc_n;
   end

   assign io_mem_req_valid = (state == REQ);
   assign io_mem_req_addr  = req_addr;
   assign io_ir_wdata      = io_mem_resp_data;
   assign io_ir_valid      = (state == FULL);
   assign io_ir_pc         = ir_pc;
   assign io_fault         = (state == FAULT);

endmodule
